// File: rtl/pcpi_initiator.sv
// pcpi_initiator
//   CPU-side master for the PCPI coprocessor interface. Accepts one command at
//   a time on a valid/ready command port, issues it to a PCPI responder, and
//   returns the responder's result (or an illegal-instruction flag when no
//   responder claims the instruction in time) on a valid/ready response port.
//
// Ports
//   clk, resetn            clock; synchronous reset, active-high (asserted = 1)
//   cmd_valid/cmd_ready    command handshake (cmd_ready = idle)
//   cmd_insn/rs1/rs2       command instruction word and operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_wr        captured pcpi_rd / pcpi_wr (both 0 when illegal)
//   rsp_illegal            no responder claimed the instruction before timeout
//   pcpi_valid/insn/rs1/rs2  registered request to the coprocessor
//   pcpi_ready/wr/rd/wait  coprocessor result, write-enable, data, busy
module pcpi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CTR_W          = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  logic              pcpi_valid_q, pcpi_valid_d;
  logic [31:0]       pcpi_insn_q, pcpi_insn_d;
  logic [31:0]       pcpi_rs1_q, pcpi_rs1_d;
  logic [31:0]       pcpi_rs2_q, pcpi_rs2_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic              rsp_illegal_q, rsp_illegal_d;

  assign cmd_ready   = (state_q == IDLE);
  assign pcpi_valid  = pcpi_valid_q;
  assign pcpi_insn   = pcpi_insn_q;
  assign pcpi_rs1    = pcpi_rs1_q;
  assign pcpi_rs2    = pcpi_rs2_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_wr      = rsp_wr_q;
  assign rsp_illegal = rsp_illegal_q;

  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    pcpi_valid_d  = pcpi_valid_q;
    pcpi_insn_d   = pcpi_insn_q;
    pcpi_rs1_d    = pcpi_rs1_q;
    pcpi_rs2_d    = pcpi_rs2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_illegal_d = rsp_illegal_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pcpi_insn_d  = cmd_insn;
          pcpi_rs1_d   = cmd_rs1;
          pcpi_rs2_d   = cmd_rs2;
          pcpi_valid_d = 1'b1;
          ctr_d        = '0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        // Ready beats wait, and both beat the timeout in the same cycle.
        if (pcpi_ready) begin
          rsp_data_d    = pcpi_rd;
          rsp_wr_d      = pcpi_wr;
          rsp_illegal_d = 1'b0;
          pcpi_valid_d  = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (pcpi_wait) begin
          ctr_d = '0;
        end else if (ctr_q == CTR_LAST) begin
          rsp_data_d    = '0;
          rsp_wr_d      = 1'b0;
          rsp_illegal_d = 1'b1;
          pcpi_valid_d  = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q       <= IDLE;
      ctr_q         <= '0;
      pcpi_valid_q  <= 1'b0;
      pcpi_insn_q   <= '0;
      pcpi_rs1_q    <= '0;
      pcpi_rs2_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_wr_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      pcpi_valid_q  <= pcpi_valid_d;
      pcpi_insn_q   <= pcpi_insn_d;
      pcpi_rs1_q    <= pcpi_rs1_d;
      pcpi_rs2_q    <= pcpi_rs2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

endmodule

// File: doc/pcpi_initiator.md
Name: pcpi_initiator

Overview:
- CPU-side master for the PCPI coprocessor interface; drives `pcpi_valid/insn/rs1/rs2` and collects `pcpi_ready/wr/rd/wait` from a PCPI responder such as `ext_pcpi_core`.
- Takes one command at a time from a valid/ready command port.
- Returns the result, or an illegal-instruction flag on timeout, on a valid/ready response port.
- Used as the issue stage in front of the approximate mul/add coprocessors, and as the bus-functional master in their benches.

Parameters:
- TIMEOUT_CYCLES, 16, number of consecutive issue cycles with neither `pcpi_ready` nor `pcpi_wait` before the instruction is declared illegal (range 2..31).
- CTR_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous reset, active-high (asserted = 1), matching the existing PCPI core hookup
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_insn  in  32  instruction word
- cmd_rs1  in  32  operand 1
- cmd_rs2  in  32  operand 2
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  32  captured pcpi_rd (0 when illegal)
- rsp_wr  out  1  captured pcpi_wr (0 when illegal)
- rsp_illegal  out  1  timeout occurred, no responder claimed the instruction
- pcpi_valid  out  1  instruction valid to coprocessor
- pcpi_insn  out  32  registered instruction
- pcpi_rs1  out  32  registered operand 1
- pcpi_rs2  out  32  registered operand 2
- pcpi_ready  in  1  coprocessor result valid
- pcpi_wr  in  1  coprocessor writes rd
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor busy, suppresses timeout

Behaviour:
- FSM states: IDLE, ISSUE, RESP. All outputs registered except cmd_ready, which is (state==IDLE).
- Reset (resetn=1 at a clock edge) forces:
  - state=IDLE, counter=0
  - pcpi_valid=0, pcpi_insn/rs1/rs2=0
  - rsp_valid=0, rsp_data=0, rsp_wr=0, rsp_illegal=0
  - Reset overrides every other event, including mid-ISSUE and mid-RESP; any in-flight command is dropped and produces no response.
- IDLE: on a cmd handshake:
  - latch insn/rs1/rs2 into the pcpi_* registers and set pcpi_valid=1 on the same edge; counter=0; go to ISSUE.
  - pcpi_valid is therefore seen high in the cycle after acceptance.
- ISSUE: pcpi_insn/rs1/rs2 are held stable. Each edge, in priority order:
  - pcpi_ready=1: capture rsp_data=pcpi_rd, rsp_wr=pcpi_wr, rsp_illegal=0; pcpi_valid=0; rsp_valid=1; go to RESP. Ready wins over wait and over timeout in the same cycle.
  - else pcpi_wait=1: counter=0; stay. No upper bound on wait.
  - else if counter==TIMEOUT_CYCLES-1: rsp_data=0, rsp_wr=0, rsp_illegal=1; pcpi_valid=0; rsp_valid=1; go to RESP.
  - else counter=counter+1.
- Timeout timing: with no ready/wait ever, pcpi_valid is high for exactly TIMEOUT_CYCLES cycles.
- Minimum latency: cmd handshake at edge N, pcpi_ready seen high at edge N+1, rsp_valid high from edge N+1.
- RESP: rsp_* fields are held stable while rsp_valid=1. On a rsp handshake: rsp_valid=0, go to IDLE; cmd_ready is high in the following cycle. No command is accepted while in RESP (strictly one outstanding).
- pcpi_ready/pcpi_wait asserted while pcpi_valid=0 are ignored.
- pcpi_wr is only sampled together with pcpi_ready.
- Counter never wraps: it saturates by leaving ISSUE.

Test Plan:
- Basic multiply:
  - Stimulus: cmd insn=0x0000000B, rs1=3, rs2=4; responder asserts wait for 3 cycles, then ready with wr=1, rd=12.
  - Required: rsp_valid with rsp_data=12, rsp_wr=1, rsp_illegal=0; pcpi_valid drops the cycle after ready.
- Unsupported instruction:
  - Stimulus: insn=0x00000076; responder silent.
  - Required: pcpi_valid high for exactly 16 cycles, then rsp_illegal=1, rsp_data=0, rsp_wr=0.
- Long wait:
  - Stimulus: responder holds wait for 40 cycles, then ready with rd=0x5A.
  - Required: no timeout; rsp_data=0x5A, rsp_illegal=0.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid; cmd_valid held high with rs1=9, rs2=10.
  - Required: cmd_ready=0 throughout; rsp fields stable; second command accepted only the cycle after the rsp handshake, result 90.
- Reset mid-issue:
  - Stimulus: resetn=1 for 1 cycle while in ISSUE with rs1=7, rs2=8.
  - Required: next cycle pcpi_valid=0, rsp_valid=0, cmd_ready=1; no response ever emitted for that command.
- Simultaneous ready and timeout:
  - Stimulus: responder asserts ready with rd=0xB4 exactly in the 16th silent cycle.
  - Required: rsp_illegal=0, rsp_data=0xB4.
